regfile_write_arbiter: RTL
==========================

# regfile_write_arbiter

Shares the single write port (we3/wa3/wd3) of the 15×32 register file among NREQ writeback requesters (ALU, load unit, multiplier) using round-robin arbitration. The arbiter has one registered output stage, so each accepted write reaches the register file exactly one cycle after its grant. Writes that target R15 are diverted to a separate PC-update port, because R15 is not stored in the register file. The block sits between the writeback sources and register_file_32.

## Interface
- NREQ, 3, number of requesters (2..8)
- DW, 32, data width
- AW, 4, register address width
- clk  in  1  clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  NREQ  request[i] is high while requester i has a write pending
- req_addr  in  NREQ×AW  destination register of requester i
- req_data  in  NREQ×DW  write data of requester i
- hold  in  1  pipeline stall; while it is high, no grant is issued
- gnt  out  NREQ  one-hot, combinational; the transfer happens on the edge where req[i]&gnt[i]
- we3  out  1  register file write enable (registered)
- wa3  out  AW  register file write address (registered)
- wd3  out  DW  register file write data (registered)
- pc_we  out  1  R15 write strobe (registered)
- pc_wd  out  DW  R15 write data (registered)
- busy  out  1  high when any req is high or when we3 or pc_we is high
- With ARB_BYPASS_EN defined, these additional ports exist:
  - ra1, ra2  in  AW  register file read addresses
  - fwd1_valid, fwd2_valid  out  1  bypass hit for the matching read port
  - fwd1_data, fwd2_data  out  DW  bypass data for the matching read port

## Operation
- Priority pointer ptr, an index in 0..NREQ-1. On reset it is 0.
- Grant selection (combinational):
  - If hold=1 or req=0, then gnt=0.
  - Otherwise gnt selects the first requester i with req[i]=1, searching from ptr upward and wrapping modulo NREQ.
- Accept on an edge where gnt[i]=1:
  - ptr becomes (i+1) mod NREQ.
  - If req_addr[i]≠15: we3, wa3 and wd3 load 1, req_addr[i] and req_data[i]; pc_we loads 0.
  - If req_addr[i]=15: pc_we and pc_wd load 1 and req_data[i]; we3 loads 0; wa3 and wd3 still load the address and data.
- Edge with no grant:
  - we3 and pc_we load 0.
  - wa3, wd3 and pc_wd keep their values.
  - ptr keeps its value.
- Requester rules:
  - A requester holds req, req_addr and req_data stable until it samples gnt high.
  - It may deassert req in the cycle after the grant, or keep req high to issue back-to-back writes.
  - A requester must not withdraw req while it is ungranted. This is a protocol error, and the block does not check for it.
- Starvation bound: a requester that holds req continuously is granted within NREQ grant cycles.
- Several requesters may write the same address. Writes land in grant order, and the later grant wins.
- Reset asserted at any point:
  - Outputs clear immediately: we3=0, pc_we=0, wa3=0, wd3=0, pc_wd=0, ptr=0.
  - gnt=0 while reset is low.
  - Any in-flight write is dropped.

## Timing
- Latency from grant edge to we3 high: 1 cycle. The register file captures the write on the following edge.
- Throughput: one write per cycle, sustained.
- gnt depends only on req, hold and ptr. It has no combinational path from req_addr or req_data.
- hold takes effect in the same cycle it rises. A write already registered in we3 still completes.
- Reset values:
  - gnt=0, we3=0, wa3=0, wd3=0, pc_we=0, pc_wd=0.
  - busy equals OR(req) once reset is released.
  - With ARB_BYPASS_EN: fwd*_valid=0.

## Configuration
- ARB_BYPASS_EN defined:
  - fwdN_valid = we3 & (raN==wa3) & (raN≠15).
  - fwdN_data = wd3.
  - Both outputs are combinational. Read ports therefore see a write during the cycle before it is committed to the register file.
- ARB_BYPASS_EN undefined:
  - The ra1, ra2, fwd* ports and their logic are absent.
  - A read in the we3 cycle returns the old register value.

## Test plan
- Reset low mid-stream, with we3=1 and wa3=5: all outputs go to 0 immediately. After release, a single req[2] is granted within 0 cycles (same cycle) and ptr becomes 0.
- req=3'b111 held for 6 cycles: gnt sequence is 001,010,100,001,010,100 and we3 stays high from the 2nd cycle on.
- req[1] with addr=7 and data=0xDEADBEEF: gnt[1] is high in cycle 0. In cycle 1, we3=1, wa3=7 and wd3=0xDEADBEEF. In cycle 2, we3=0.
- req[0] with addr=15 and data=0x100: in the next cycle pc_we=1, pc_wd=0x100 and we3=0.
- hold=1 for 3 cycles with req=3'b010: gnt=0 and we3=0 throughout. gnt[1] is high in the cycle hold falls.
- With ARB_BYPASS_EN, write r3=0x55 and ra1=3: fwd1_valid=1 and fwd1_data=0x55 in the we3 cycle. With ra1=15, fwd1_valid=0.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ writeback sources,
// with R15 writes diverted to a PC-update port. Optional read bypass: define ARB_BYPASS_EN.
module regfile_write_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic               hold,
  output logic [NREQ-1:0]    gnt,
  output logic               we3,
  output logic [AW-1:0]      wa3,
  output logic [DW-1:0]      wd3,
  output logic               pc_we,
  output logic [DW-1:0]      pc_wd,
  output logic               busy
`ifdef ARB_BYPASS_EN
  ,
  input  logic [AW-1:0]      ra1,
  input  logic [AW-1:0]      ra2,
  output logic               fwd1_valid,
  output logic               fwd2_valid,
  output logic [DW-1:0]      fwd1_data,
  output logic [DW-1:0]      fwd2_data
`endif
);

  localparam int PW = $clog2(NREQ);
  localparam logic [AW-1:0] PC_ADDR = AW'(15);

  // Handshake: requester i transfers on the rising edge where req[i] & gnt[i];
  // it holds req/req_addr/req_data stable until then.

  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] ptr_next;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  // Search upward from ptr, wrapping; only req, hold and ptr feed the grant.
  always_comb begin
    int unsigned idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    if (reset && !hold) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(ptr) + k) % NREQ;
        if (!found && req[idx]) begin
          found        = 1'b1;
          gnt[idx]     = 1'b1;
          gnt_idx      = PW'(idx);
        end
      end
    end
  end

  assign sel_addr = req_addr[gnt_idx*AW +: AW];
  assign sel_data = req_data[gnt_idx*DW +: DW];
  assign ptr_next = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + PW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr   <= '0;
      we3   <= 1'b0;
      wa3   <= '0;
      wd3   <= '0;
      pc_we <= 1'b0;
      pc_wd <= '0;
    end else if (|gnt) begin
      ptr <= ptr_next;
      wa3 <= sel_addr;
      wd3 <= sel_data;
      if (sel_addr == PC_ADDR) begin
        we3   <= 1'b0;
        pc_we <= 1'b1;
        pc_wd <= sel_data;
      end else begin
        we3   <= 1'b1;
        pc_we <= 1'b0;
      end
    end else begin
      we3   <= 1'b0;
      pc_we <= 1'b0;
    end
  end

  assign busy = (|req) | we3 | pc_we;

`ifdef ARB_BYPASS_EN
  // Reads see the pending write one cycle before the register file commits it.
  assign fwd1_valid = we3 && (ra1 == wa3) && (ra1 != PC_ADDR);
  assign fwd2_valid = we3 && (ra2 == wa3) && (ra2 != PC_ADDR);
  assign fwd1_data  = wd3;
  assign fwd2_data  = wd3;
`endif

endmodule
